// File: rtl/par_serial_tx_if.sv
// Handshake and serial-output bundle between the upstream byte source and par_serial_tx.
// The master drives bytes and the enable; the slave returns ready, the serial bit and the alignment status.
interface par_serial_tx_if;
    logic       enb;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    modport master (
        output enb, data_in, valid_in,
        input  ready_out, data_out, active_out
    );

    modport slave (
        input  enb, data_in, valid_in,
        output ready_out, data_out, active_out
    );
endinterface

// File: rtl/par_serial_tx.sv
// Byte-to-serial transmitter: sends SYNC_BYTES COM symbols after reset, then serialises
// accepted bytes MSB first in fixed 8-cycle slots, filling empty slots with IDLE.
module par_serial_tx #(
    parameter int         SYNC_BYTES = 4,
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C
) (
    input  logic                 clk_8f,
    input  logic                 rst,
    par_serial_tx_if.slave       bus
);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic [3:0] r_sync_cnt;

    state_t     w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] w_shreg_nxt;
    logic [3:0] w_sync_cnt_nxt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shreg_nxt    = r_shreg;
        w_sync_cnt_nxt = r_sync_cnt;

        if (bus.enb) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd0) begin
                unique case (r_state)
                    ST_SYNC: begin
                        w_shreg_nxt    = COM;
                        w_sync_cnt_nxt = r_sync_cnt + 4'd1;
                        if (w_sync_cnt_nxt == 4'(SYNC_BYTES))
                            w_state_nxt = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        w_shreg_nxt = bus.valid_in ? bus.data_in : IDLE;
                    end
                    default: w_state_nxt = ST_SYNC;
                endcase
            end else begin
                w_shreg_nxt = {r_shreg[6:0], 1'b0};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_8f or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_SYNC;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'd0;
            r_sync_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
        end
    end

    // The serial bit is the shift-register MSB itself, so it inherits the register's reset and hold.
    assign bus.data_out   = r_shreg[7];
    assign bus.active_out = (r_state == ST_ACTIVE);
    assign bus.ready_out  = (r_state == ST_ACTIVE) && (r_bit_cnt == 3'd0) && bus.enb;

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx: a slot-level reference model queues expected serial
// bits as bytes are loaded; an independent monitor pops and compares them after each edge.
module tb_par_serial_tx;

    localparam int         SB   = 4;
    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;

    logic clk_8f = 1'b0;
    logic rst_n  = 1'b0;

    par_serial_tx_if bus();

    par_serial_tx #(.SYNC_BYTES(SB), .COM(COM), .IDLE(IDLE)) dut (
        .clk_8f (clk_8f),
        .rst    (rst_n),
        .bus    (bus)
    );

    always #5 clk_8f = ~clk_8f;

    int   total = 0;
    int   bad   = 0;
    bit   exp_q[$];
    int   en_edges = 0;
    int   slots    = 0;
    logic hold_bit = 1'b0;

    task automatic check(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // One clock cycle of stimulus; the model reasons in whole slots and enabled-edge counts.
    task automatic step(input bit en, input bit v, input logic [7:0] d);
        logic [7:0] b;
        @(negedge clk_8f);
        bus.enb      = en;
        bus.valid_in = v;
        bus.data_in  = d;
        #1;
        check("ready_out", bus.ready_out, en && (en_edges % 8 == 0) && (slots >= SB));
        check("active_out", bus.active_out, slots >= SB);
        if (en) begin
            if (en_edges % 8 == 0) begin
                if (slots < SB)  b = COM;
                else if (v)      b = d;
                else             b = IDLE;
                for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
                slots++;
            end
            en_edges++;
        end
    endtask

    // Byte offered at a load edge, then 7 mid-slot cycles with junk valid/data that must be ignored.
    task automatic send_slot(input bit v, input logic [7:0] d);
        step(1'b1, v, d);
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 8'($urandom));
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk_8f);
        #2;
        rst_n        = 1'b0;
        bus.enb      = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        check("rst data_out", bus.data_out, 1'b0);
        check("rst ready_out", bus.ready_out, 1'b0);
        check("rst active_out", bus.active_out, 1'b0);
        exp_q.delete();
        en_edges = 0;
        slots    = 0;
        hold_bit = 1'b0;
        repeat (cycles) begin
            @(negedge clk_8f);
            check("rst hold data_out", bus.data_out, 1'b0);
            check("rst hold active_out", bus.active_out, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    // Monitor: after every enabled edge the next queued bit must appear; otherwise data_out holds.
    initial begin
        bit en_s;
        bit e;
        forever begin
            @(posedge clk_8f);
            if (rst_n) begin
                en_s = bus.enb;
                #1;
                if (en_s) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard empty", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", bus.data_out, e);
                        hold_bit = e;
                    end
                end else begin
                    check("data_out hold", bus.data_out, hold_bit);
                end
            end
        end
    end

    initial begin
        bus.enb      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        // Reset with clock running, then the full sync period plus one IDLE slot.
        apply_reset(3);
        for (int s = 0; s < SB + 1; s++) send_slot(1'b0, 8'($urandom));

        // Data transfer, back-to-back bytes, then an empty slot.
        send_slot(1'b1, 8'hA5);
        send_slot(1'b1, 8'h3C);
        send_slot(1'b1, 8'hFF);
        send_slot(1'b0, 8'h00);

        // Enable stall of 5 cycles in the middle of a byte.
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom));

        // Randomized traffic with random enable gaps.
        for (int i = 0; i < 600; i++)
            step(($urandom % 5) != 0, 1'($urandom), 8'($urandom));

        // Reset in mid-slot while ACTIVE; the full sync must repeat before data is accepted.
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        apply_reset(2);
        for (int i = 0; i < 8 * (SB + 3); i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 200; i++)
            step(($urandom % 4) != 0, 1'($urandom), 8'($urandom));

        // Let the last queued bits drain through the monitor.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        @(negedge clk_8f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/par_serial_tx.md
# par_serial_tx

Byte-to-serial transmitter for the PHY transmit path. Runs on the fastest clock and owns its own 8-cycle byte slot, aligned with the divided clocks from the clock generator. After reset it sends a fixed number of COM symbols to establish alignment, then serialises accepted data bytes MSB first. Empty slots are filled with IDLE symbols. Its output feeds the serial line and the receive-side serial-to-parallel stage.

## Interface
Parameters:
- SYNC_BYTES, 4: number of COM bytes sent after reset before entering ACTIVE (range 1–15).
- COM, 8'hBC: alignment symbol.
- IDLE, 8'h7C: fill symbol for slots with no accepted data.

Ports:
- clk_8f  input  1  bit clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; one clock, no other clock domains.
- enb  input  1  enable; low freezes all state.
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in holds a byte to send.
- ready_out  output  1  transmitter will accept data_in at this edge.
- data_out  output  1  serial bit, MSB first; driven directly from the shift-register MSB (registered).
- active_out  output  1  high while in ACTIVE state.

## Operation
- Registers:
  - bit_cnt[2:0]: slot position.
  - shreg[7:0]
  - sync_cnt[3:0]
  - state: SYNC or ACTIVE.
- Reset (rst=0, asynchronous, immediate):
  - bit_cnt=0, shreg=0, sync_cnt=0, state=SYNC.
  - data_out=0, ready_out=0, active_out=0.
- Every enabled edge increments bit_cnt, wrapping 7→0.
- Edge with enb=1 and bit_cnt==0 (load edge): shreg is loaded with the next byte:
  - SYNC: COM; sync_cnt+1. If the new sync_cnt==SYNC_BYTES, state becomes ACTIVE at this same edge.
  - ACTIVE, valid_in=1: data_in; the byte is accepted.
  - ACTIVE, valid_in=0: IDLE.
- Edge with enb=1 and bit_cnt!=0: shreg shifts left by one, LSB filled with 0.
- ready_out = (state==ACTIVE) && (bit_cnt==0) && enb. Combinational from registers and enb.
- A byte is accepted only when ready_out && valid_in at a rising edge. The upstream stage must hold data_in/valid_in until that edge.
- enb=0: bit_cnt, shreg, sync_cnt and state hold; data_out holds; ready_out=0.
- active_out = (state==ACTIVE). Once ACTIVE, the block stays there until reset.
- No back-pressure beyond ready_out and no buffering; at most one byte in flight.

## Timing
- Load-to-output latency: a byte loaded at edge k drives its MSB on data_out after edge k and its LSB after edge k+7. The next load is edge k+8.
- First edge after reset release with enb=1 is a load edge. data_out shows COM bit 7 (1) immediately after it.
- Sync period: SYNC_BYTES×8 enabled cycles. With default 4, edges 1, 9, 17, 25 load COM and edge 25 sets active_out.
  - The first ready_out is at the 5th load opportunity, edge 33.
  - A valid byte presented then appears on data_out bits after edges 33–40.
- Serial sequence for a byte: MSB first. COM appears as 1,0,1,1,1,1,0,0; IDLE appears as 0,1,1,1,1,1,0,0.
- enb low for N cycles stretches the current slot by exactly N cycles; no bit is lost or duplicated.
- Reset asserted mid-slot: outputs clear without waiting for a clock edge. After release, the sync sequence restarts from sync_cnt=0.
- valid_in high while ready_out=0 (SYNC state, mid-slot, or enb=0): ignored; nothing is accepted.

## Test plan
- Reset values: hold rst=0 with clock running → data_out=0, ready_out=0, active_out=0. Assert rst low mid-slot → outputs clear before the next edge.
- Sync sequence: release rst, enb=1, valid_in=0 → 32 serial bits form 4× 8'hBC; active_out rises after edge 25; the next 8 bits are 8'h7C.
- Data transfer: valid_in=1, data_in=8'hA5 held from edge 33 → accepted at edge 33; data_out after edges 33–40 is 1,0,1,0,0,1,0,1; ready_out high only at edges 33, 41, 49….
- Back-to-back and gap: send 8'h3C, 8'hFF, then valid_in=0 → serial stream is 3C, FF, 7C with no gap cycles.
- Enable stall: drop enb for 5 cycles after the 3rd bit of 8'hA5 → data_out holds bit 3 for 5 extra cycles; the remaining bits follow in order; ready_out=0 throughout the stall.
- Reset mid-operation: assert rst during ACTIVE mid-byte, then release → active_out=0 immediately; the full 4× 8'hBC sync is resent before the next ready_out.
